// File: rtl/alu_dispatch_queue.sv
// alu_dispatch_queue: in-order FIFO between decoder and ALU reservation station.
// Ports: decoder in_* with in_valid/in_ready, CDB snoop (alu/mem), RS vacancy
// flags, registered out_* bundle; ALU_DISPATCH_BYPASS_EN enables empty bypass.
`ifndef ROB_RANGE
`define ROB_RANGE 4:0
`endif

module alu_dispatch_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_input,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_Vj,
  input  logic [31:0]      in_Vk,
  input  logic [`ROB_RANGE] in_Qj,
  input  logic [`ROB_RANGE] in_Qk,
  input  logic [`ROB_RANGE] in_dest,
  input  logic [`ROB_RANGE] cdb_alu_rob_id,
  input  logic [`ROB_RANGE] cdb_mem_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic [31:0]      cdb_mem_value,
  input  logic             rs_has_no_vacancy,
  input  logic             rs_has_one_vacancy,
  output logic             out_enabled,
  output logic [3:0]       out_op,
  output logic [31:0]      out_Vj,
  output logic [31:0]      out_Vk,
  output logic [`ROB_RANGE] out_Qj,
  output logic [`ROB_RANGE] out_Qk,
  output logic [`ROB_RANGE] out_dest
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [`ROB_RANGE] rob_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    rob_t        qj;
    rob_t        qk;
    rob_t        dest;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          out_q;
  ent_t          in_ent;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic slot_ok;
  logic enq;
  logic issue;
  logic bypass;
  logic push;

  // ALU broadcast wins when both buses carry the same tag.
  function automatic ent_t snoop(input ent_t e);
    ent_t r;
    r = e;
    if (e.qj != '0 && e.qj == cdb_alu_rob_id) begin
      r.vj = cdb_alu_value;
      r.qj = '0;
    end else if (e.qj != '0 && e.qj == cdb_mem_rob_id) begin
      r.vj = cdb_mem_value;
      r.qj = '0;
    end
    if (e.qk != '0 && e.qk == cdb_alu_rob_id) begin
      r.vk = cdb_alu_value;
      r.qk = '0;
    end else if (e.qk != '0 && e.qk == cdb_mem_rob_id) begin
      r.vk = cdb_mem_value;
      r.qk = '0;
    end
    return r;
  endfunction

  assign in_ent = '{
    op:   in_op,
    vj:   in_Vj,
    vk:   in_Vk,
    qj:   in_Qj,
    qk:   in_Qk,
    dest: in_dest
  };

  assign in_ready = (count < CW'(DEPTH)) && !flush_input;
  assign enq      = in_valid && in_ready;

  // An op already in the output register is not yet counted by the
  // station, so a single vacancy is taken by it.
  assign slot_ok = !rs_has_no_vacancy &&
                   !(out_enabled && rs_has_one_vacancy);
  assign issue   = (count != '0) && slot_ok;

`ifdef ALU_DISPATCH_BYPASS_EN
  assign bypass = (count == '0) && enq && slot_ok;
`else
  assign bypass = 1'b0;
`endif

  assign push = enq && !bypass;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_enabled <= 1'b0;
      out_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_input) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_enabled <= 1'b0;
      out_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= snoop(mem[i]);
      end
      if (push) begin
        mem[tail] <= snoop(in_ent);
        tail      <= tail + 1'b1;
      end
      if (issue) begin
        out_q       <= snoop(mem[head]);
        head        <= head + 1'b1;
        out_enabled <= 1'b1;
      end else if (bypass) begin
        out_q       <= snoop(in_ent);
        out_enabled <= 1'b1;
      end else begin
        out_enabled <= 1'b0;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_op   = out_q.op;
  assign out_Vj   = out_q.vj;
  assign out_Vk   = out_q.vk;
  assign out_Qj   = out_q.qj;
  assign out_Qk   = out_q.qk;
  assign out_dest = out_q.dest;

endmodule

// File: tb/tb_alu_dispatch_queue.sv
// tb_alu_dispatch_queue: randomized bench for alu_dispatch_queue against
// a queue-based reference model.
`ifndef ROB_RANGE
`define ROB_RANGE 4:0
`endif

module tb_alu_dispatch_queue;

  localparam int DEPTH = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic             rst_n_in;
  logic             flush_input;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [31:0]      in_Vj, in_Vk;
  logic [`ROB_RANGE] in_Qj, in_Qk, in_dest;
  logic [`ROB_RANGE] cdb_alu_rob_id, cdb_mem_rob_id;
  logic [31:0]      cdb_alu_value, cdb_mem_value;
  logic             rs_has_no_vacancy, rs_has_one_vacancy;
  logic             out_enabled;
  logic [3:0]       out_op;
  logic [31:0]      out_Vj, out_Vk;
  logic [`ROB_RANGE] out_Qj, out_Qk, out_dest;

  alu_dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .flush_input(flush_input),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_Vj(in_Vj),
    .in_Vk(in_Vk),
    .in_Qj(in_Qj),
    .in_Qk(in_Qk),
    .in_dest(in_dest),
    .cdb_alu_rob_id(cdb_alu_rob_id),
    .cdb_mem_rob_id(cdb_mem_rob_id),
    .cdb_alu_value(cdb_alu_value),
    .cdb_mem_value(cdb_mem_value),
    .rs_has_no_vacancy(rs_has_no_vacancy),
    .rs_has_one_vacancy(rs_has_one_vacancy),
    .out_enabled(out_enabled),
    .out_op(out_op),
    .out_Vj(out_Vj),
    .out_Vk(out_Vk),
    .out_Qj(out_Qj),
    .out_Qk(out_Qk),
    .out_dest(out_dest)
  );

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [`ROB_RANGE] qj;
    logic [`ROB_RANGE] qk;
    logic [`ROB_RANGE] dest;
  } op_t;

  op_t  mq[$];
  op_t  mo;
  bit   me;
  int   total = 0;
  int   bad = 0;
  bit   rec = 0;
  logic [`ROB_RANGE] seen[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void snp(inout logic [31:0] v,
                              inout logic [`ROB_RANGE] q);
    if (q != 0 && q == cdb_alu_rob_id) begin
      v = cdb_alu_value;
      q = 0;
    end else if (q != 0 && q == cdb_mem_rob_id) begin
      v = cdb_mem_value;
      q = 0;
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    me = 0;
    mo = '{default: '0};
  endfunction

  function automatic bit model_ready();
    return (mq.size() < DEPTH) && !flush_input;
  endfunction

  function automatic void model_step();
    int  pre;
    bit  slot, enq, iss, byp;
    op_t x;
    if (flush_input) begin
      model_clear();
      return;
    end
    pre  = mq.size();
    slot = !rs_has_no_vacancy && !(me && rs_has_one_vacancy);
    enq  = in_valid && (pre < DEPTH);
    foreach (mq[i]) begin
      snp(mq[i].vj, mq[i].qj);
      snp(mq[i].vk, mq[i].qk);
    end
    x = '{in_op, in_Vj, in_Vk, in_Qj, in_Qk, in_dest};
    snp(x.vj, x.qj);
    snp(x.vk, x.qk);
    iss = (pre > 0) && slot;
    byp = 0;
`ifdef ALU_DISPATCH_BYPASS_EN
    byp = (pre == 0) && enq && slot;
`endif
    if (iss) begin
      mo = mq.pop_front();
      me = 1;
    end else if (byp) begin
      mo = x;
      me = 1;
    end else begin
      me = 0;
    end
    if (enq && !byp) mq.push_back(x);
  endfunction

  task automatic check_out();
    chk("out_enabled", out_enabled, me);
    chk("out_op", out_op, mo.op);
    chk("out_Vj", out_Vj, mo.vj);
    chk("out_Vk", out_Vk, mo.vk);
    chk("out_Qj", out_Qj, mo.qj);
    chk("out_Qk", out_Qk, mo.qk);
    chk("out_dest", out_dest, mo.dest);
  endtask

  task automatic step();
    #1;
    chk("in_ready", in_ready, model_ready());
    model_step();
    @(posedge clk_in);
    #1;
    check_out();
    if (rec && out_enabled) seen.push_back(out_dest);
  endtask

  task automatic idle();
    in_valid = 0;
    in_op = 0;
    in_Vj = 0;
    in_Vk = 0;
    in_Qj = 0;
    in_Qk = 0;
    in_dest = 0;
    cdb_alu_rob_id = 0;
    cdb_mem_rob_id = 0;
    cdb_alu_value = 0;
    cdb_mem_value = 0;
    flush_input = 0;
  endtask

  task automatic put(input int dest, input int qj);
    in_valid = 1;
    in_op = 4'($urandom);
    in_Vj = $urandom;
    in_Vk = $urandom;
    in_Qj = 5'(qj);
    in_Qk = 0;
    in_dest = 5'(dest);
  endtask

  task automatic drain();
    idle();
    rs_has_no_vacancy = 0;
    rs_has_one_vacancy = 0;
    repeat (DEPTH + 3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    idle();
    rs_has_no_vacancy = 0;
    rs_has_one_vacancy = 0;
    model_clear();

    // Reset with in_valid pulsing
    rst_n_in = 0;
    put(5, 0);
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_en", out_enabled, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_vj", out_Vj, 0);
    @(negedge clk_in);
    rst_n_in = 1;
    idle();
    #1;
    chk("rst_ready", in_ready, 1);
    @(posedge clk_in);
    #1;

    // Streaming dest 1..5
    rec = 1;
    for (int i = 1; i <= 5; i++) begin
      put(i, 0);
      step();
    end
    idle();
    repeat (3) step();
    rec = 0;
    chk("stream_n", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      chk("stream_dest", seen[i], i + 1);

    // Throttle: no vacancy fills queue, then one-vacancy gating
    drain();
    rs_has_no_vacancy = 1;
    for (int i = 0; i < 5; i++) begin
      put(10 + i, 0);
      step();
    end
    idle();
    #1;
    chk("full_ready", in_ready, 0);
    rs_has_no_vacancy = 0;
    rs_has_one_vacancy = 1;
    step();
    chk("one_vac_issue", out_enabled, 1);
    step();
    chk("one_vac_block", out_enabled, 0);
    step();
    chk("one_vac_resume", out_enabled, 1);

    // Snoop: queued op picks up ALU broadcast
    drain();
    rs_has_no_vacancy = 1;
    put(20, 3);
    step();
    idle();
    cdb_alu_rob_id = 3;
    cdb_alu_value = 32'hDEADBEEF;
    step();
    idle();
    rs_has_no_vacancy = 0;
    step();
    chk("snoop_vj", out_Vj, 32'hDEADBEEF);
    chk("snoop_qj", out_Qj, 0);

    // Both CDBs carry the tag on the enqueue cycle: ALU wins
    drain();
    put(21, 3);
    cdb_alu_rob_id = 3;
    cdb_mem_rob_id = 3;
    cdb_alu_value = 32'h11;
    cdb_mem_value = 32'h22;
    step();
    idle();
    for (int i = 0; i < 4 && !(out_enabled && out_dest == 21); i++)
      step();
    chk("prio_seen", out_dest, 21);
    chk("prio_vj", out_Vj, 32'h11);

    // Flush with 3 queued and one on the output
    drain();
    rs_has_no_vacancy = 1;
    for (int i = 0; i < 4; i++) begin
      put(30 + i, 0);
      step();
    end
    idle();
    rs_has_no_vacancy = 0;
    step();
    chk("pre_flush_en", out_enabled, 1);
    flush_input = 1;
    step();
    chk("flush_en", out_enabled, 0);
    chk("flush_dest", out_dest, 0);
    idle();
    put(7, 0);
    step();
    idle();
    for (int i = 0; i < 4 && !out_enabled; i++) step();
    chk("post_flush_dest", out_dest, 7);

    // Latency on an empty queue
    drain();
    put(9, 0);
    step();
    idle();
    lat = 1;
    while (!(out_enabled && out_dest == 9) && lat < 6) begin
      step();
      lat++;
    end
`ifdef ALU_DISPATCH_BYPASS_EN
    chk("latency", lat, 1);
`else
    chk("latency", lat, 2);
`endif

    // Randomized traffic
    drain();
    for (int n = 0; n < 3000; n++) begin
      in_valid = 1'($urandom);
      in_op = 4'($urandom);
      in_Vj = $urandom;
      in_Vk = $urandom;
      in_Qj = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      in_Qk = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      in_dest = 5'($urandom_range(1, 31));
      cdb_alu_rob_id = 5'($urandom_range(0, 7));
      cdb_mem_rob_id = 5'($urandom_range(0, 7));
      cdb_alu_value = $urandom;
      cdb_mem_value = $urandom;
      rs_has_no_vacancy = ($urandom_range(0, 3) == 0);
      rs_has_one_vacancy = ($urandom_range(0, 2) == 0);
      flush_input = ($urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset mid-operation
    idle();
    rs_has_no_vacancy = 1;
    for (int i = 0; i < 3; i++) begin
      put(40 + i, 0);
      step();
    end
    idle();
    rs_has_no_vacancy = 0;
    step();
    chk("pre_arst_en", out_enabled, 1);
    rst_n_in = 0;
    #2;
    model_clear();
    chk("arst_en", out_enabled, 0);
    chk("arst_dest", out_dest, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk_in);
    rst_n_in = 1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
